mips_mc_controller: RTL and testbench



---
 rtl/mips_mc_pkg.sv | 68 ++++++
 rtl/mips_alu_decoder.sv | 41 ++++
 rtl/mips_mc_controller.sv | 148 ++++++++++++++
 tb/tb_mips_mc_controller.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multicycle MIPS controller.
// Covers state codes, opcode/funct fields, ALU operation codes and datapath mux selects.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IMMEX  = 4'd9,
    S_IMMWB  = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [4:0] ALU_AND = 5'b00000;
  localparam logic [4:0] ALU_OR  = 5'b00001;
  localparam logic [4:0] ALU_ADD = 5'b00010;
  localparam logic [4:0] ALU_XOR = 5'b00011;
  localparam logic [4:0] ALU_NOR = 5'b00100;
  localparam logic [4:0] ALU_SUB = 5'b00110;
  localparam logic [4:0] ALU_SLT = 5'b00111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  localparam logic [2:0] SRCB_B      = 3'b000;
  localparam logic [2:0] SRCB_FOUR   = 3'b001;
  localparam logic [2:0] SRCB_SIMM   = 3'b010;
  localparam logic [2:0] SRCB_SIMMSH = 3'b011;
  localparam logic [2:0] SRCB_ZIMM   = 3'b100;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_imm_op(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_ANDI) ||
           (op == OP_ORI)  || (op == OP_XORI);
  endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// ALU-control decoder: maps ALUOp plus the latched funct/opcode to an ALU operation code.
module mips_alu_decoder
  import mips_mc_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  input  logic [5:0] op,
  output logic [4:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_XOR:  alu_control = ALU_XOR;
          FN_NOR:  alu_control = ALU_NOR;
          FN_SLT:  alu_control = ALU_SLT;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: begin
        case (op)
          OP_ADDI: alu_control = ALU_ADD;
          OP_SLTI: alu_control = ALU_SLT;
          OP_ANDI: alu_control = ALU_AND;
          OP_ORI:  alu_control = ALU_OR;
          OP_XORI: alu_control = ALU_XOR;
          default: alu_control = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: Moore FSM, Op/Funct latch and datapath control decode.
// Outputs are combinational from the state register and the latched instruction fields.
module mips_mc_controller
  import mips_mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       lorD,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUSrcB,
  output logic       ALUSrcA,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       PCWrite,
  output logic       Branch,
  output logic       Branch2,
  output logic       RegWrite,
  output logic [1:0] ALUOp,
  output logic [4:0] ALUControl,
  output logic [3:0] state
);

  state_t     state_q;
  state_t     dec_st;
  logic [5:0] op_q;
  logic [5:0] funct_q;
  logic       ir_wr, pc_wr, mem_wr, reg_wr, br, br2;

  // The PC advances at the end of FETCH, so later states decode the captured fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      funct_q <= '0;
    end else begin
      if (IRWrite) begin
        op_q    <= Op;
        funct_q <= Funct;
      end
      case (state_q)
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          if (op_q == OP_LW || op_q == OP_SW)       state_q <= S_MEMADR;
          else if (op_q == OP_RTYPE)                state_q <= S_EXEC;
          else if (op_q == OP_BEQ || op_q == OP_BNE) state_q <= S_BRANCH;
          else if (is_imm_op(op_q))                 state_q <= S_IMMEX;
          else if (op_q == OP_J)                    state_q <= S_JUMP;
          else                                      state_q <= S_FETCH;
        end
        S_MEMADR: begin
          if (op_q == OP_LW)      state_q <= S_MEMRD;
          else if (op_q == OP_SW) state_q <= S_MEMWR;
          else                    state_q <= S_FETCH;
        end
        S_MEMRD: state_q <= S_MEMWB;
        S_EXEC:  state_q <= S_ALUWB;
        S_IMMEX: state_q <= S_IMMWB;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // While reset is held the mux selects look like FETCH and every write enable is masked.
  assign dec_st = reset ? S_FETCH : state_q;

  always_comb begin
    MemtoReg = 1'b0;
    RegDst   = 1'b0;
    lorD     = 1'b0;
    PCSrc    = PCSRC_ALU;
    ALUSrcB  = SRCB_B;
    ALUSrcA  = 1'b0;
    ALUOp    = ALUOP_ADD;
    ir_wr    = 1'b0;
    pc_wr    = 1'b0;
    mem_wr   = 1'b0;
    reg_wr   = 1'b0;
    br       = 1'b0;
    br2      = 1'b0;
    case (dec_st)
      S_FETCH: begin
        ALUSrcB = SRCB_FOUR;
        ir_wr   = 1'b1;
        pc_wr   = 1'b1;
      end
      S_DECODE: ALUSrcB = SRCB_SIMMSH;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_SIMM;
      end
      S_MEMRD: lorD = 1'b1;
      S_MEMWB: begin
        MemtoReg = 1'b1;
        reg_wr   = 1'b1;
      end
      S_MEMWR: begin
        lorD   = 1'b1;
        mem_wr = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegDst = 1'b1;
        reg_wr = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_SUB;
        PCSrc   = PCSRC_ALUOUT;
        br      = (op_q == OP_BEQ);
        br2     = (op_q == OP_BNE);
      end
      S_IMMEX: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_IMM;
        ALUSrcB = (op_q == OP_ANDI || op_q == OP_ORI || op_q == OP_XORI) ? SRCB_ZIMM : SRCB_SIMM;
      end
      S_IMMWB: reg_wr = 1'b1;
      S_JUMP: begin
        PCSrc = PCSRC_JUMP;
        pc_wr = 1'b1;
      end
      default: ;
    endcase
  end

  assign IRWrite  = ir_wr  & ~reset;
  assign PCWrite  = pc_wr  & ~reset;
  assign MemWrite = mem_wr & ~reset;
  assign RegWrite = reg_wr & ~reset;
  assign Branch   = br     & ~reset;
  assign Branch2  = br2    & ~reset;
  assign state    = state_q;

  mips_alu_decoder u_alu_dec (
    .alu_op      (ALUOp),
    .funct       (funct_q),
    .op          (op_q),
    .alu_control (ALUControl)
  );

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed table-driven bench for the multicycle MIPS controller.
module tb_mips_mc_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] Op = 6'b0;
  logic [5:0] Funct = 6'b0;
  logic       MemtoReg, RegDst, lorD, ALUSrcA, IRWrite, MemWrite, PCWrite;
  logic       Branch, Branch2, RegWrite;
  logic [1:0] PCSrc, ALUOp;
  logic [2:0] ALUSrcB;
  logic [4:0] ALUControl;
  logic [3:0] state;

  always #5 clk = ~clk;

  mips_mc_controller dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .lorD(lorD), .PCSrc(PCSrc),
    .ALUSrcB(ALUSrcB), .ALUSrcA(ALUSrcA), .IRWrite(IRWrite), .MemWrite(MemWrite),
    .PCWrite(PCWrite), .Branch(Branch), .Branch2(Branch2), .RegWrite(RegWrite),
    .ALUOp(ALUOp), .ALUControl(ALUControl), .state(state)
  );

  // Control word layout: MemtoReg RegDst lorD PCSrc[2] ALUSrcB[3] ALUSrcA IRWrite
  // MemWrite PCWrite Branch Branch2 RegWrite ALUOp[2] ALUControl[5]
  logic [21:0] act_cw;
  assign act_cw = {MemtoReg, RegDst, lorD, PCSrc, ALUSrcB, ALUSrcA, IRWrite,
                   MemWrite, PCWrite, Branch, Branch2, RegWrite, ALUOp, ALUControl};

  function automatic logic [21:0] mk(input logic m2r, input logic rdst, input logic iord,
                                     input logic [1:0] pcs, input logic [2:0] srcb,
                                     input logic srca, input logic irw, input logic memw,
                                     input logic pcw, input logic b1, input logic b2,
                                     input logic regw, input logic [1:0] aop,
                                     input logic [4:0] ctl);
    return {m2r, rdst, iord, pcs, srcb, srca, irw, memw, pcw, b1, b2, regw, aop, ctl};
  endfunction

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [3:0]  st;
    logic [21:0] cw;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h want %0h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t v(input logic r, input logic [5:0] o, input logic [5:0] f,
                             input logic [3:0] s, input logic [21:0] c);
    vec_t t;
    t.rst = r; t.op = o; t.funct = f; t.st = s; t.cw = c;
    return t;
  endfunction

  initial begin
    logic [21:0] w_rst, w_fetch, w_dec, w_madr, w_mrd, w_mwb, w_mwr, w_exslt, w_awb;
    logic [21:0] w_beq, w_bne, w_ori, w_addi, w_slti, w_iwb, w_jmp;
    int cnt;

    w_rst   = mk(0,0,0,2'b00,3'b001,0,0,0,0,0,0,0,2'b00,5'b00010);
    w_fetch = mk(0,0,0,2'b00,3'b001,0,1,0,1,0,0,0,2'b00,5'b00010);
    w_dec   = mk(0,0,0,2'b00,3'b011,0,0,0,0,0,0,0,2'b00,5'b00010);
    w_madr  = mk(0,0,0,2'b00,3'b010,1,0,0,0,0,0,0,2'b00,5'b00010);
    w_mrd   = mk(0,0,1,2'b00,3'b000,0,0,0,0,0,0,0,2'b00,5'b00010);
    w_mwb   = mk(1,0,0,2'b00,3'b000,0,0,0,0,0,0,1,2'b00,5'b00010);
    w_mwr   = mk(0,0,1,2'b00,3'b000,0,0,1,0,0,0,0,2'b00,5'b00010);
    w_exslt = mk(0,0,0,2'b00,3'b000,1,0,0,0,0,0,0,2'b10,5'b00111);
    w_awb   = mk(0,1,0,2'b00,3'b000,0,0,0,0,0,0,1,2'b00,5'b00010);
    w_beq   = mk(0,0,0,2'b01,3'b000,1,0,0,0,1,0,0,2'b01,5'b00110);
    w_bne   = mk(0,0,0,2'b01,3'b000,1,0,0,0,0,1,0,2'b01,5'b00110);
    w_ori   = mk(0,0,0,2'b00,3'b100,1,0,0,0,0,0,0,2'b11,5'b00001);
    w_addi  = mk(0,0,0,2'b00,3'b010,1,0,0,0,0,0,0,2'b11,5'b00010);
    w_slti  = mk(0,0,0,2'b00,3'b010,1,0,0,0,0,0,0,2'b11,5'b00111);
    w_iwb   = mk(0,0,0,2'b00,3'b000,0,0,0,0,0,0,1,2'b00,5'b00010);
    w_jmp   = mk(0,0,0,2'b10,3'b000,0,0,0,1,0,0,0,2'b00,5'b00010);

    // lw after two reset cycles
    vecs.push_back(v(1, 6'b100011, 6'h00, 4'd0,  w_rst));
    vecs.push_back(v(0, 6'b100011, 6'h00, 4'd0,  w_fetch));
    vecs.push_back(v(0, 6'b100011, 6'h00, 4'd1,  w_dec));
    vecs.push_back(v(0, 6'b100011, 6'h00, 4'd2,  w_madr));
    vecs.push_back(v(0, 6'b100011, 6'h00, 4'd3,  w_mrd));
    vecs.push_back(v(0, 6'b100011, 6'h00, 4'd4,  w_mwb));
    // R-type slt
    vecs.push_back(v(0, 6'b000000, 6'b101010, 4'd0, w_fetch));
    vecs.push_back(v(0, 6'b000000, 6'b101010, 4'd1, w_dec));
    vecs.push_back(v(0, 6'b000000, 6'b101010, 4'd6, w_exslt));
    vecs.push_back(v(0, 6'b000000, 6'b101010, 4'd7, w_awb));
    // beq then bne
    vecs.push_back(v(0, 6'b000100, 6'h00, 4'd0,  w_fetch));
    vecs.push_back(v(0, 6'b000100, 6'h00, 4'd1,  w_dec));
    vecs.push_back(v(0, 6'b000100, 6'h00, 4'd8,  w_beq));
    vecs.push_back(v(0, 6'b000101, 6'h00, 4'd0,  w_fetch));
    vecs.push_back(v(0, 6'b000101, 6'h00, 4'd1,  w_dec));
    vecs.push_back(v(0, 6'b000101, 6'h00, 4'd8,  w_bne));
    // ori then addi
    vecs.push_back(v(0, 6'b001101, 6'h00, 4'd0,  w_fetch));
    vecs.push_back(v(0, 6'b001101, 6'h00, 4'd1,  w_dec));
    vecs.push_back(v(0, 6'b001101, 6'h00, 4'd9,  w_ori));
    vecs.push_back(v(0, 6'b001101, 6'h00, 4'd10, w_iwb));
    vecs.push_back(v(0, 6'b001000, 6'h00, 4'd0,  w_fetch));
    vecs.push_back(v(0, 6'b001000, 6'h00, 4'd1,  w_dec));
    vecs.push_back(v(0, 6'b001000, 6'h00, 4'd9,  w_addi));
    vecs.push_back(v(0, 6'b001000, 6'h00, 4'd10, w_iwb));
    // j with Op changed to 000000 during DECODE
    vecs.push_back(v(0, 6'b000010, 6'h00, 4'd0,  w_fetch));
    vecs.push_back(v(0, 6'b000000, 6'h00, 4'd1,  w_dec));
    vecs.push_back(v(0, 6'b000000, 6'h00, 4'd11, w_jmp));
    // undefined opcode
    vecs.push_back(v(0, 6'b111111, 6'h00, 4'd0,  w_fetch));
    vecs.push_back(v(0, 6'b111111, 6'h00, 4'd1,  w_dec));
    // lw interrupted by reset in MEMRD
    vecs.push_back(v(0, 6'b100011, 6'h00, 4'd0,  w_fetch));
    vecs.push_back(v(0, 6'b100011, 6'h00, 4'd1,  w_dec));
    vecs.push_back(v(0, 6'b100011, 6'h00, 4'd2,  w_madr));
    vecs.push_back(v(1, 6'b100011, 6'h00, 4'd3,  w_rst));
    // sw
    vecs.push_back(v(0, 6'b101011, 6'h00, 4'd0,  w_fetch));
    vecs.push_back(v(0, 6'b101011, 6'h00, 4'd1,  w_dec));
    vecs.push_back(v(0, 6'b101011, 6'h00, 4'd2,  w_madr));
    vecs.push_back(v(0, 6'b101011, 6'h00, 4'd5,  w_mwr));
    // slti, then fetch an R-type nor
    vecs.push_back(v(0, 6'b001010, 6'h00, 4'd0,  w_fetch));
    vecs.push_back(v(0, 6'b001010, 6'h00, 4'd1,  w_dec));
    vecs.push_back(v(0, 6'b001010, 6'h00, 4'd9,  w_slti));
    vecs.push_back(v(0, 6'b001010, 6'h00, 4'd10, w_iwb));
    vecs.push_back(v(0, 6'b000000, 6'b100111, 4'd0, w_fetch));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset = vecs[i].rst;
      Op    = vecs[i].op;
      Funct = vecs[i].funct;
      #1;
      chk("state", i, 32'(state), 32'(vecs[i].st));
      chk("ctrl",  i, 32'(act_cw), 32'(vecs[i].cw));
    end

    // nor reaches EXEC within a bounded number of cycles
    cnt = 0;
    do begin
      @(negedge clk);
      #1;
      cnt++;
    end while (state != 4'd6 && cnt < 8);
    chk("nor_exec_state", 0, 32'(state), 32'd6);
    chk("nor_exec_cycles", 0, 32'(cnt), 32'd2);
    chk("nor_ctl", 0, 32'(ALUControl), 32'(5'b00100));
    @(negedge clk); #1;
    chk("nor_wb_state", 0, 32'(state), 32'd7);

    // unknown funct falls back to ADD
    @(negedge clk);
    Op = 6'b000000;
    Funct = 6'b111111;
    #1;
    chk("unk_fetch_state", 0, 32'(state), 32'd0);
    @(negedge clk); #1;
    chk("unk_dec_state", 0, 32'(state), 32'd1);
    @(negedge clk); #1;
    chk("unk_exec_state", 0, 32'(state), 32'd6);
    chk("unk_ctl", 0, 32'(ALUControl), 32'(5'b00010));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
